// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kbd_pkg
// Brief   : Keyboard scan-code (set 2) and ASCII constants shared by the
//           keyboard FSM and the scan-to-ASCII path.
// Rev     : 1.0
// ============================================================================
package kbd_pkg;

  // Scan codes (set 2)
  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] SHIFT1 = 8'h12;
  localparam logic [7:0] SHIFT2 = 8'h59;
  localparam logic [7:0] CAPS   = 8'h58;
  localparam logic [7:0] ENTER  = 8'h5A;
  localparam logic [7:0] BKSP   = 8'h66;
  localparam logic [7:0] SPACE  = 8'h29;

  // ASCII characters
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] SP = 8'h20;

  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/scan2ascii.sv
`default_nettype none
// ============================================================================
// Module  : scan2ascii
// Brief   : Combinational scan-code (set 2) to ASCII translator.
// Rev     : 1.0
// ============================================================================
module scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       letter_case,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] w_letter_base;

  assign w_letter_base = letter_case ? ASCII_UPPER_A : ASCII_LOWER_A;

  always_comb begin
    ascii = 8'h00;
    valid = 1'b1;
    case (scan_code)
      // letters a..z in alphabetical order
      8'h1C: ascii = w_letter_base + 8'd0;
      8'h32: ascii = w_letter_base + 8'd1;
      8'h21: ascii = w_letter_base + 8'd2;
      8'h23: ascii = w_letter_base + 8'd3;
      8'h24: ascii = w_letter_base + 8'd4;
      8'h2B: ascii = w_letter_base + 8'd5;
      8'h34: ascii = w_letter_base + 8'd6;
      8'h33: ascii = w_letter_base + 8'd7;
      8'h43: ascii = w_letter_base + 8'd8;
      8'h3B: ascii = w_letter_base + 8'd9;
      8'h42: ascii = w_letter_base + 8'd10;
      8'h4B: ascii = w_letter_base + 8'd11;
      8'h3A: ascii = w_letter_base + 8'd12;
      8'h31: ascii = w_letter_base + 8'd13;
      8'h44: ascii = w_letter_base + 8'd14;
      8'h4D: ascii = w_letter_base + 8'd15;
      8'h15: ascii = w_letter_base + 8'd16;
      8'h2D: ascii = w_letter_base + 8'd17;
      8'h1B: ascii = w_letter_base + 8'd18;
      8'h2C: ascii = w_letter_base + 8'd19;
      8'h3C: ascii = w_letter_base + 8'd20;
      8'h2A: ascii = w_letter_base + 8'd21;
      8'h1D: ascii = w_letter_base + 8'd22;
      8'h22: ascii = w_letter_base + 8'd23;
      8'h35: ascii = w_letter_base + 8'd24;
      8'h1A: ascii = w_letter_base + 8'd25;
      // digits are case independent
      8'h45: ascii = ASCII_ZERO + 8'd0;
      8'h16: ascii = ASCII_ZERO + 8'd1;
      8'h1E: ascii = ASCII_ZERO + 8'd2;
      8'h26: ascii = ASCII_ZERO + 8'd3;
      8'h25: ascii = ASCII_ZERO + 8'd4;
      8'h2E: ascii = ASCII_ZERO + 8'd5;
      8'h36: ascii = ASCII_ZERO + 8'd6;
      8'h3D: ascii = ASCII_ZERO + 8'd7;
      8'h3E: ascii = ASCII_ZERO + 8'd8;
      8'h46: ascii = ASCII_ZERO + 8'd9;
      SPACE: ascii = SP;
      ENTER: ascii = CR;
      BKSP:  ascii = BS;
      default: begin
        ascii = 8'h00;
        valid = 1'b0;
      end
    endcase
  end

endmodule : scan2ascii
`default_nettype wire

// File: rtl/scan_ascii_fifo.sv
`default_nettype none
// ============================================================================
// Module  : scan_ascii_fifo
// Brief   : Scan-code to ASCII translation feeding a first-word-fall-through
//           character FIFO with sticky overflow.
// Rev     : 1.0
// ============================================================================
module scan_ascii_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            scan_code,
  input  logic                  scan_code_ready,
  input  logic                  letter_case,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [7:0]            ascii_out,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned             c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     c_full_count = c_depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]     c_cnt_one    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0]   c_ptr_one    = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic [7:0]            w_ascii;
  logic                  w_valid;
  logic                  w_write_req;
  logic                  w_pop;
  logic                  w_do_write;
  logic                  w_drop;

  scan2ascii u_scan2ascii (
    .scan_code   (scan_code),
    .letter_case (letter_case),
    .ascii       (w_ascii),
    .valid       (w_valid)
  );

  assign empty = (r_count == '0);
  assign full  = (r_count == c_full_count);

  assign w_write_req = scan_code_ready & w_valid;
  assign w_pop       = rd_en & ~empty;
  // A pop frees the slot the write needs, so write+pop at full is lossless.
  assign w_do_write  = w_write_req & (~full | w_pop);
  assign w_drop      = w_write_req & full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= w_ascii;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_write) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_write, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      // Setting takes priority over clearing.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ascii_out = empty ? 8'h00 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule : scan_ascii_fifo
`default_nettype wire

// File: doc/scan_ascii_fifo.md
# scan_ascii_fifo

Translates scan-code ticks from the keyboard front end into ASCII characters and buffers them for the consumer (text display / game logic). Sits directly downstream of the keyboard FSM and consumes its `scan_code`, `scan_code_ready` and `letter_case_out`. Unmapped codes are discarded, and mapped characters go into a first-word-fall-through FIFO with a rd_en pop handshake.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2**DEPTH_LOG2 entries (8).
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `scan_code`, input, 8: scan code (set 2), valid when `scan_code_ready`=1.
- `scan_code_ready`, input, 1: single-cycle tick, one character event.
- `letter_case`, input, 1: 1 = uppercase letters, 0 = lowercase. Sampled with the tick.
- `rd_en`, input, 1: pop the head entry this cycle.
- `clr_ovf`, input, 1: clears `overflow`.
- `ascii_out`, output, 8: head-of-FIFO character. 0x00 when empty.
- `empty`, output, 1: FIFO holds 0 entries.
- `full`, output, 1: FIFO holds 2**DEPTH_LOG2 entries.
- `count`, output, DEPTH_LOG2+1: current occupancy.
- `overflow`, output, 1: sticky. A mapped character was dropped because the FIFO was full.

## Operation
- Translation (combinational):
  - Letters 0x1C,0x32,0x21,0x23,0x24,0x2B,0x34,0x33,0x43,0x3B,0x42,0x4B,0x3A,0x31,0x44,0x4D,0x15,0x2D,0x1B,0x2C,0x3C,0x2A,0x1D,0x22,0x35,0x1A map to a–z. The result is 0x61+i, or 0x41+i when `letter_case`=1.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'–'9' (0x30–0x39), independent of case.
  - 0x29 maps to 0x20 (space), 0x5A to 0x0D (enter), 0x66 to 0x08 (backspace).
  - Any other code is unmapped.
- Write condition: `scan_code_ready`=1 AND the code is mapped. The entry is written at that clock edge.
- Write while full with no pop in the same cycle: the character is dropped and `overflow` is set.
- Simultaneous write and pop while full: both happen. `count` stays at full and nothing is dropped.
- Unmapped tick: no write, no state change, `overflow` unaffected.
- `rd_en` while empty is ignored: pointers and `count` unchanged, no underflow.
- Simultaneous write and pop while empty: the write happens, the pop is ignored, and `count` becomes 1.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is tracked separately, and `full`/`empty` derive from `count`.
- `overflow` priority: a set in the same cycle as `clr_ovf` wins and `overflow` stays 1.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `overflow`=0, `ascii_out`=0x00, read and write pointers = 0.
- Reset mid-operation discards all buffered entries immediately (asynchronous).
- Latency: a tick at edge N makes the character visible on `ascii_out` (if the FIFO was empty) with `empty`=0 after edge N. The consumer can sample it in the cycle following the tick.
- Pop: with `rd_en`=1 at edge N, `ascii_out` shows the next entry (or 0x00) after edge N.
- Throughput: one write and one pop per cycle, sustained.
- All outputs are glitch-free functions of registered state. `ascii_out` is a combinational read of the memory at the read pointer, gated by `empty`.

## Structure
- Shared package `kbd_pkg`:
  - Scan-code constants: BREAK, SHIFT1, SHIFT2, CAPS, ENTER, BKSP, SPACE.
  - ASCII constants: CR, BS, SP.
  - The keyboard FSM imports the same package.
- Sub-module `scan2ascii`: purely combinational. Inputs are `scan_code` and `letter_case`; outputs are `ascii` [7:0] and `valid`.
- The top level holds the FIFO memory, pointers, `count` and `overflow`.

## Test plan
- Reset, then tick 0x1C with `letter_case`=0: `ascii_out`=0x61 next cycle, `empty`=0, `count`=1. Pop: `empty`=1, `ascii_out`=0x00.
- Ticks 0x33 (case=1), 0x45, 0x5A, then pop three times: outputs are 0x48, 0x30, 0x0D in order.
- Tick 0x76 (unmapped, Esc): `count` stays 0, `overflow` stays 0.
- Nine mapped ticks with no pops: `full`=1 and `count`=8 after the eighth; the ninth sets `overflow`=1 and the first eight characters are intact. Pulse `clr_ovf`: `overflow`=0.
- With the FIFO full, tick 0x29 together with `rd_en`: the head is popped, 0x20 is appended, `count`=8, `overflow`=0.
- Write 5 characters, pop 5, write 6, pop all: order is preserved across pointer wrap. Assert `reset` mid-sequence: `count`=0 and `empty`=1 immediately.
